// File: rtl/cpu_control_fsm_if.sv
// Control bundle between the multi-cycle CPU datapath and its control FSM.
// The datapath (master) supplies the opcode held in the instruction register
// and the ALU zero flag; the FSM (slave) returns every datapath control strobe
// plus its current state for debug visibility.
interface cpu_control_fsm_if;
    logic [5:0] op;
    logic       zero;
    logic       InsMemRW;
    logic       IRWre;
    logic       PCWre;
    logic [1:0] PCSrc;
    logic       ALUSrcA;
    logic       ALUSrcB;
    logic [2:0] ALUOp;
    logic       RegWre;
    logic       RegDst;
    logic       mRD;
    logic       mWR;
    logic       DBDataSrc;
    logic       ExtSel;
    logic [3:0] state;

    modport master (
        output op, zero,
        input  InsMemRW, IRWre, PCWre, PCSrc, ALUSrcA, ALUSrcB, ALUOp,
        input  RegWre, RegDst, mRD, mWR, DBDataSrc, ExtSel, state
    );

    modport slave (
        input  op, zero,
        output InsMemRW, IRWre, PCWre, PCSrc, ALUSrcA, ALUSrcB, ALUOp,
        output RegWre, RegDst, mRD, mWR, DBDataSrc, ExtSel, state
    );
endinterface

// File: rtl/cpu_control_fsm.sv
// Multi-cycle CPU control unit.
// Instruction flow: IF -> ID -> (EXE_R -> WB_R | EXE_LS -> MEM [-> WB_L] |
// EXE_B) -> IF, with j retiring in ID and halt parking in HALT until reset.
// Control outputs are a pure function of the state register and the opcode;
// the zero flag only steers PCSrc in EXE_B. While Reset is high the state is
// held at IF and every output is forced low, so an in-flight instruction is
// aborted without any further register or memory write strobe.
// The state register is visible on bus.state for debug.
module cpu_control_fsm (
    input  logic             CLK,
    input  logic             Reset,
    cpu_control_fsm_if.slave bus
);

    typedef enum logic [3:0] {
        S_IF     = 4'b0000,
        S_ID     = 4'b0001,
        S_EXE_R  = 4'b0010,
        S_EXE_LS = 4'b0011,
        S_EXE_B  = 4'b0100,
        S_MEM    = 4'b0101,
        S_WB_R   = 4'b0110,
        S_WB_L   = 4'b0111,
        S_HALT   = 4'b1000
    } state_t;

    localparam logic [5:0] OP_ADD   = 6'b000000;
    localparam logic [5:0] OP_SUB   = 6'b000001;
    localparam logic [5:0] OP_ADDIU = 6'b000010;
    localparam logic [5:0] OP_AND   = 6'b010000;
    localparam logic [5:0] OP_OR    = 6'b010001;
    localparam logic [5:0] OP_ORI   = 6'b010010;
    localparam logic [5:0] OP_SLL   = 6'b011000;
    localparam logic [5:0] OP_SW    = 6'b110000;
    localparam logic [5:0] OP_LW    = 6'b110001;
    localparam logic [5:0] OP_BEQ   = 6'b110100;
    localparam logic [5:0] OP_BNE   = 6'b110101;
    localparam logic [5:0] OP_J     = 6'b111000;
    localparam logic [5:0] OP_HALT  = 6'b111111;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_SLL = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_AND = 3'b100;

    localparam logic [1:0] PC_SEQ    = 2'b00;
    localparam logic [1:0] PC_BRANCH = 2'b01;
    localparam logic [1:0] PC_JUMP   = 2'b10;

    state_t r_state;
    state_t w_next_state;

    // One-hot opcode decode; unrecognised opcodes fall into the add class.
    logic w_op_add;
    logic w_op_sub;
    logic w_op_addiu;
    logic w_op_and;
    logic w_op_or;
    logic w_op_ori;
    logic w_op_sll;
    logic w_op_sw;
    logic w_op_lw;
    logic w_op_beq;
    logic w_op_bne;
    logic w_op_j;
    logic w_op_halt;

    logic w_is_rfmt;
    logic w_uses_imm;
    logic w_branch_taken;
    logic [2:0] w_alu_op_dec;

    // Unmasked control values, before the reset override.
    logic       w_ins_mem_rw;
    logic       w_ir_wre;
    logic       w_pc_wre;
    logic [1:0] w_pc_src;
    logic       w_alu_src_a;
    logic       w_alu_src_b;
    logic [2:0] w_alu_op;
    logic       w_reg_wre;
    logic       w_reg_dst;
    logic       w_m_rd;
    logic       w_m_wr;
    logic       w_db_data_src;
    logic       w_ext_sel;

    // Opcode decode into one flag per instruction class.
    always_comb begin
        w_op_add   = 1'b0;
        w_op_sub   = 1'b0;
        w_op_addiu = 1'b0;
        w_op_and   = 1'b0;
        w_op_or    = 1'b0;
        w_op_ori   = 1'b0;
        w_op_sll   = 1'b0;
        w_op_sw    = 1'b0;
        w_op_lw    = 1'b0;
        w_op_beq   = 1'b0;
        w_op_bne   = 1'b0;
        w_op_j     = 1'b0;
        w_op_halt  = 1'b0;
        case (bus.op)
            OP_ADD:   w_op_add   = 1'b1;
            OP_SUB:   w_op_sub   = 1'b1;
            OP_ADDIU: w_op_addiu = 1'b1;
            OP_AND:   w_op_and   = 1'b1;
            OP_OR:    w_op_or    = 1'b1;
            OP_ORI:   w_op_ori   = 1'b1;
            OP_SLL:   w_op_sll   = 1'b1;
            OP_SW:    w_op_sw    = 1'b1;
            OP_LW:    w_op_lw    = 1'b1;
            OP_BEQ:   w_op_beq   = 1'b1;
            OP_BNE:   w_op_bne   = 1'b1;
            OP_J:     w_op_j     = 1'b1;
            OP_HALT:  w_op_halt  = 1'b1;
            default:  w_op_add   = 1'b1;
        endcase
    end

    assign w_is_rfmt      = w_op_add | w_op_sub | w_op_and | w_op_or | w_op_sll;
    assign w_uses_imm     = w_op_addiu | w_op_ori | w_op_lw | w_op_sw;
    assign w_branch_taken = (w_op_beq & bus.zero) | (w_op_bne & ~bus.zero);

    // ALU function for the current opcode; only presented during EXE/MEM/WB.
    always_comb begin
        w_alu_op_dec = ALU_ADD;
        if (w_op_beq | w_op_bne | w_op_sub) begin
            w_alu_op_dec = ALU_SUB;
        end else if (w_op_or | w_op_ori) begin
            w_alu_op_dec = ALU_OR;
        end else if (w_op_and) begin
            w_alu_op_dec = ALU_AND;
        end else if (w_op_sll) begin
            w_alu_op_dec = ALU_SLL;
        end
    end

    // State register, forced to IF asynchronously by Reset.
    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            r_state <= S_IF;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic: dispatch in ID, join back to IF after the last cycle.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IF: w_next_state = S_ID;
            S_ID: begin
                if (w_op_j) begin
                    w_next_state = S_IF;
                end else if (w_op_halt) begin
                    w_next_state = S_HALT;
                end else if (w_op_beq | w_op_bne) begin
                    w_next_state = S_EXE_B;
                end else if (w_op_lw | w_op_sw) begin
                    w_next_state = S_EXE_LS;
                end else begin
                    w_next_state = S_EXE_R;
                end
            end
            S_EXE_R:  w_next_state = S_WB_R;
            S_EXE_LS: w_next_state = S_MEM;
            S_EXE_B:  w_next_state = S_IF;
            S_MEM:    w_next_state = w_op_lw ? S_WB_L : S_IF;
            S_WB_R:   w_next_state = S_IF;
            S_WB_L:   w_next_state = S_IF;
            S_HALT:   w_next_state = S_HALT;
            default:  w_next_state = S_IF;
        endcase
    end

    // Control outputs: opcode-static selects plus per-state enables.
    always_comb begin
        w_ins_mem_rw  = 1'b0;
        w_ir_wre      = 1'b0;
        w_pc_wre      = 1'b0;
        w_pc_src      = PC_SEQ;
        w_alu_op      = ALU_ADD;
        w_reg_wre     = 1'b0;
        w_m_rd        = 1'b0;
        w_m_wr        = 1'b0;
        w_alu_src_a   = w_op_sll;
        w_alu_src_b   = w_uses_imm;
        w_reg_dst     = w_is_rfmt;
        w_db_data_src = w_op_lw;
        w_ext_sel     = ~w_op_ori;
        case (r_state)
            S_IF: begin
                w_ins_mem_rw = 1'b1;
                w_ir_wre     = 1'b1;
            end
            S_ID: begin
                // j retires here, so it owns the PC update in this cycle.
                if (w_op_j) begin
                    w_pc_wre = 1'b1;
                    w_pc_src = PC_JUMP;
                end
            end
            S_EXE_R, S_EXE_LS: begin
                w_alu_op = w_alu_op_dec;
            end
            S_EXE_B: begin
                w_alu_op = w_alu_op_dec;
                w_pc_wre = 1'b1;
                if (w_branch_taken) begin
                    w_pc_src = PC_BRANCH;
                end
            end
            S_MEM: begin
                w_alu_op = w_alu_op_dec;
                if (w_op_sw) begin
                    w_m_wr   = 1'b1;
                    w_pc_wre = 1'b1;
                end
                if (w_op_lw) begin
                    w_m_rd = 1'b1;
                end
            end
            S_WB_R: begin
                w_alu_op  = w_alu_op_dec;
                w_reg_wre = 1'b1;
                w_pc_wre  = 1'b1;
            end
            S_WB_L: begin
                // Hold the read so load data stays valid through writeback.
                w_alu_op  = w_alu_op_dec;
                w_reg_wre = 1'b1;
                w_pc_wre  = 1'b1;
                w_m_rd    = w_op_lw;
            end
            default: begin
                // HALT: every enable stays at its default of 0.
            end
        endcase
    end

    // Reset overrides every output combinationally, independent of CLK.
    assign bus.InsMemRW  = Reset ? 1'b0 : w_ins_mem_rw;
    assign bus.IRWre     = Reset ? 1'b0 : w_ir_wre;
    assign bus.PCWre     = Reset ? 1'b0 : w_pc_wre;
    assign bus.PCSrc     = Reset ? 2'b00 : w_pc_src;
    assign bus.ALUSrcA   = Reset ? 1'b0 : w_alu_src_a;
    assign bus.ALUSrcB   = Reset ? 1'b0 : w_alu_src_b;
    assign bus.ALUOp     = Reset ? 3'b000 : w_alu_op;
    assign bus.RegWre    = Reset ? 1'b0 : w_reg_wre;
    assign bus.RegDst    = Reset ? 1'b0 : w_reg_dst;
    assign bus.mRD       = Reset ? 1'b0 : w_m_rd;
    assign bus.mWR       = Reset ? 1'b0 : w_m_wr;
    assign bus.DBDataSrc = Reset ? 1'b0 : w_db_data_src;
    assign bus.ExtSel    = Reset ? 1'b0 : w_ext_sel;
    assign bus.state     = Reset ? 4'b0000 : r_state;

endmodule

// File: tb/tb_cpu_control_fsm.sv
// Bench for cpu_control_fsm: a table of single instructions run back to back,
// then hand-written halt and mid-store reset sequences. Each sampled cycle
// compares {state, control word} against an entry queued when stimulus is set.
module tb_cpu_control_fsm;

    localparam logic [3:0] ST_IF     = 4'b0000;
    localparam logic [3:0] ST_ID     = 4'b0001;
    localparam logic [3:0] ST_EXE_R  = 4'b0010;
    localparam logic [3:0] ST_EXE_LS = 4'b0011;
    localparam logic [3:0] ST_EXE_B  = 4'b0100;
    localparam logic [3:0] ST_MEM    = 4'b0101;
    localparam logic [3:0] ST_WB_R   = 4'b0110;
    localparam logic [3:0] ST_WB_L   = 4'b0111;
    localparam logic [3:0] ST_HALT   = 4'b1000;

    localparam logic [5:0] OP_ADD   = 6'b000000;
    localparam logic [5:0] OP_SUB   = 6'b000001;
    localparam logic [5:0] OP_ADDIU = 6'b000010;
    localparam logic [5:0] OP_AND   = 6'b010000;
    localparam logic [5:0] OP_OR    = 6'b010001;
    localparam logic [5:0] OP_ORI   = 6'b010010;
    localparam logic [5:0] OP_SLL   = 6'b011000;
    localparam logic [5:0] OP_SW    = 6'b110000;
    localparam logic [5:0] OP_LW    = 6'b110001;
    localparam logic [5:0] OP_BEQ   = 6'b110100;
    localparam logic [5:0] OP_BNE   = 6'b110101;
    localparam logic [5:0] OP_J     = 6'b111000;
    localparam logic [5:0] OP_HALT  = 6'b111111;

    // Clock / reset
    logic CLK = 1'b0;
    logic Reset;
    always #5 CLK = ~CLK;

    cpu_control_fsm_if bus ();

    cpu_control_fsm dut (
        .CLK   (CLK),
        .Reset (Reset),
        .bus   (bus)
    );

    typedef struct {
        logic [5:0]  op;
        logic        zero;
        bit          zero_rand;
        int          len;
        logic [19:0] seq;
    } vec_t;

    vec_t        vecs[15];
    logic [19:0] exp_q[$];
    int          checks   = 0;
    int          failures = 0;

    function automatic logic [19:0] mkseq(input logic [3:0] s0, input logic [3:0] s1,
                                          input logic [3:0] s2, input logic [3:0] s3,
                                          input logic [3:0] s4);
        return {s4, s3, s2, s1, s0};
    endfunction

    // Reference control word:
    // {InsMemRW, IRWre, PCWre, PCSrc, ALUSrcA, ALUSrcB, ALUOp,
    //  RegWre, RegDst, mRD, mWR, DBDataSrc, ExtSel}
    function automatic logic [15:0] model(input logic [3:0] st, input logic [5:0] op,
                                          input logic z);
        logic is_sub, is_addiu, is_and, is_or, is_ori, is_sll, is_sw, is_lw;
        logic is_beq, is_bne, is_j, is_halt, is_add, rfmt, last, in_exec;
        logic [1:0] pcsrc;
        logic [2:0] aluop;
        is_sub   = (op == OP_SUB);
        is_addiu = (op == OP_ADDIU);
        is_and   = (op == OP_AND);
        is_or    = (op == OP_OR);
        is_ori   = (op == OP_ORI);
        is_sll   = (op == OP_SLL);
        is_sw    = (op == OP_SW);
        is_lw    = (op == OP_LW);
        is_beq   = (op == OP_BEQ);
        is_bne   = (op == OP_BNE);
        is_j     = (op == OP_J);
        is_halt  = (op == OP_HALT);
        is_add   = !(is_sub || is_addiu || is_and || is_or || is_ori || is_sll ||
                     is_sw || is_lw || is_beq || is_bne || is_j || is_halt);
        rfmt     = is_add || is_sub || is_and || is_or || is_sll;
        in_exec  = (st == ST_EXE_R) || (st == ST_EXE_LS) || (st == ST_EXE_B) ||
                   (st == ST_MEM) || (st == ST_WB_R) || (st == ST_WB_L);
        last     = (st == ST_ID && is_j) || (st == ST_EXE_B) || (st == ST_MEM && is_sw) ||
                   (st == ST_WB_R) || (st == ST_WB_L);
        pcsrc = 2'b00;
        if (last && is_j) pcsrc = 2'b10;
        else if (last && st == ST_EXE_B && ((is_beq && z) || (is_bne && !z))) pcsrc = 2'b01;
        aluop = 3'b000;
        if (in_exec) begin
            if (is_beq || is_bne || is_sub) aluop = 3'b001;
            else if (is_or || is_ori)       aluop = 3'b011;
            else if (is_and)                aluop = 3'b100;
            else if (is_sll)                aluop = 3'b010;
        end
        return {st == ST_IF, st == ST_IF, last, pcsrc, is_sll,
                is_addiu || is_ori || is_lw || is_sw, aluop,
                (st == ST_WB_R) || (st == ST_WB_L), rfmt,
                is_lw && (st == ST_MEM || st == ST_WB_L), is_sw && (st == ST_MEM),
                is_lw, !is_ori};
    endfunction

    // Driver tasks
    task automatic push_state(input logic [3:0] st);
        exp_q.push_back({st, model(st, bus.op, bus.zero)});
    endtask

    task automatic push_reset();
        exp_q.push_back(20'h0);
    endtask

    // Scoreboard compare
    task automatic compare(input string name);
        logic [19:0] exp_v, act_v;
        checks++;
        act_v = {bus.state, bus.InsMemRW, bus.IRWre, bus.PCWre, bus.PCSrc, bus.ALUSrcA,
                 bus.ALUSrcB, bus.ALUOp, bus.RegWre, bus.RegDst, bus.mRD, bus.mWR,
                 bus.DBDataSrc, bus.ExtSel};
        if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL %s: scoreboard empty, got state=%b ctrl=%b", name,
                     act_v[19:16], act_v[15:0]);
        end else begin
            exp_v = exp_q.pop_front();
            if (act_v !== exp_v) begin
                failures++;
                $display("FAIL %s: got state=%b ctrl=%b, expected state=%b ctrl=%b",
                         name, act_v[19:16], act_v[15:0], exp_v[19:16], exp_v[15:0]);
            end
        end
    endtask

    // Entered just after a rising edge with the DUT in IF; leaves it the same way.
    task automatic run_vec(input int idx);
        logic [3:0] st;
        bus.op   = vecs[idx].op;
        bus.zero = vecs[idx].zero_rand ? 1'($urandom_range(0, 1)) : vecs[idx].zero;
        for (int k = 0; k < vecs[idx].len; k++) begin
            st = vecs[idx].seq[4*k +: 4];
            push_state(st);
            @(negedge CLK);
            compare($sformatf("vec%0d op=%b z=%b cyc%0d", idx, bus.op, bus.zero, k));
            @(posedge CLK);
            #1;
        end
    endtask

    initial begin
        vecs[0]  = '{OP_ADD,   1'b0, 1'b1, 4, mkseq(ST_IF, ST_ID, ST_EXE_R, ST_WB_R, ST_IF)};
        vecs[1]  = '{OP_SUB,   1'b0, 1'b1, 4, mkseq(ST_IF, ST_ID, ST_EXE_R, ST_WB_R, ST_IF)};
        vecs[2]  = '{OP_ADDIU, 1'b0, 1'b1, 4, mkseq(ST_IF, ST_ID, ST_EXE_R, ST_WB_R, ST_IF)};
        vecs[3]  = '{OP_AND,   1'b0, 1'b1, 4, mkseq(ST_IF, ST_ID, ST_EXE_R, ST_WB_R, ST_IF)};
        vecs[4]  = '{OP_OR,    1'b0, 1'b1, 4, mkseq(ST_IF, ST_ID, ST_EXE_R, ST_WB_R, ST_IF)};
        vecs[5]  = '{OP_ORI,   1'b0, 1'b1, 4, mkseq(ST_IF, ST_ID, ST_EXE_R, ST_WB_R, ST_IF)};
        vecs[6]  = '{OP_SLL,   1'b0, 1'b1, 4, mkseq(ST_IF, ST_ID, ST_EXE_R, ST_WB_R, ST_IF)};
        vecs[7]  = '{OP_SW,    1'b0, 1'b1, 4, mkseq(ST_IF, ST_ID, ST_EXE_LS, ST_MEM, ST_IF)};
        vecs[8]  = '{OP_LW,    1'b0, 1'b1, 5, mkseq(ST_IF, ST_ID, ST_EXE_LS, ST_MEM, ST_WB_L)};
        vecs[9]  = '{OP_BEQ,   1'b1, 1'b0, 3, mkseq(ST_IF, ST_ID, ST_EXE_B, ST_IF, ST_IF)};
        vecs[10] = '{OP_BEQ,   1'b0, 1'b0, 3, mkseq(ST_IF, ST_ID, ST_EXE_B, ST_IF, ST_IF)};
        vecs[11] = '{OP_BNE,   1'b0, 1'b0, 3, mkseq(ST_IF, ST_ID, ST_EXE_B, ST_IF, ST_IF)};
        vecs[12] = '{OP_BNE,   1'b1, 1'b0, 3, mkseq(ST_IF, ST_ID, ST_EXE_B, ST_IF, ST_IF)};
        vecs[13] = '{OP_J,     1'b0, 1'b1, 2, mkseq(ST_IF, ST_ID, ST_IF, ST_IF, ST_IF)};
        vecs[14] = '{6'b101010, 1'b0, 1'b1, 4, mkseq(ST_IF, ST_ID, ST_EXE_R, ST_WB_R, ST_IF)};

        // Reset: everything low before any clock edge, and while held across edges.
        Reset    = 1'b1;
        bus.op   = OP_ADD;
        bus.zero = 1'b0;
        #2;
        push_reset();
        compare("reset_async");
        @(posedge CLK);
        #1;
        push_reset();
        compare("reset_held");
        Reset = 1'b0;

        // Table of single instructions, back to back.
        for (int i = 0; i < 15; i++) begin
            run_vec(i);
        end

        // halt: IF, ID, then parked in HALT for 20 cycles.
        bus.op   = OP_HALT;
        bus.zero = 1'($urandom_range(0, 1));
        for (int k = 0; k < 22; k++) begin
            push_state(k == 0 ? ST_IF : (k == 1 ? ST_ID : ST_HALT));
            @(negedge CLK);
            compare($sformatf("halt cyc%0d", k));
            @(posedge CLK);
            #1;
        end
        #2;
        Reset = 1'b1;
        #1;
        push_reset();
        compare("halt_reset_async");
        @(posedge CLK);
        #1;
        Reset = 1'b0;

        // sw interrupted by reset in MEM: mWR must drop before the next edge.
        bus.op   = OP_SW;
        bus.zero = 1'b0;
        for (int k = 0; k < 4; k++) begin
            push_state(k == 0 ? ST_IF : (k == 1 ? ST_ID : (k == 2 ? ST_EXE_LS : ST_MEM)));
            @(negedge CLK);
            compare($sformatf("sw_abort cyc%0d", k));
            if (k < 3) begin
                @(posedge CLK);
                #1;
            end
        end
        #1;
        Reset = 1'b1;
        #1;
        push_reset();
        compare("sw_reset_mid_mem");
        @(posedge CLK);
        #1;
        push_reset();
        compare("sw_reset_across_edge");
        Reset = 1'b0;

        // Recovery: a full add, then back in IF.
        run_vec(0);
        push_state(ST_IF);
        @(negedge CLK);
        compare("final_if");

        if (exp_q.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
